// File: rtl/mem_wr_arbiter.sv
// Two per-requester FIFOs merged round-robin onto one registered word write port; byte strobes under `WARB_BYTE_STROBE_EN`.
// Latency: push edge t -> mem_we high after edge t+1; backpressure: reqN_ready_o = FIFO not full (no same-cycle pop credit).

module mem_wr_arbiter_fifo #(
  parameter int DEPTH = 2,
  parameter int W     = 8
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         push_i,
  input  logic [W-1:0] dat_i,
  input  logic         pop_i,
  output logic [W-1:0] dat_o,
  output logic         empty_o,
  output logic         full_o
);
  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] CNT_FULL = (PW+1)'(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wptr_q, rptr_q;
  logic [PW:0]   cnt_q;
  logic          do_push, do_pop;

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == CNT_FULL);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign dat_o   = mem_q[rptr_q];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + PW'(1);
      if (do_pop)  rptr_q <= rptr_q + PW'(1);
      cnt_q <= cnt_q + (PW+1)'(do_push) - (PW+1)'(do_pop);
    end
  end

  // Storage needs no reset: an entry is only read after it has been written.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wptr_q] <= dat_i;
  end
endmodule

module mem_wr_arbiter #(
  parameter int DEPTH = 2,
  parameter int AW    = 7,
  parameter int DW    = 16
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          req0_valid_i,
  output logic          req0_ready_o,
  input  logic [AW-1:0] req0_addr_i,
  input  logic [DW-1:0] req0_data_i,
`ifdef WARB_BYTE_STROBE_EN
  input  logic [1:0]    req0_strb_i,
`endif
  input  logic          req1_valid_i,
  output logic          req1_ready_o,
  input  logic [AW-1:0] req1_addr_i,
  input  logic [DW-1:0] req1_data_i,
`ifdef WARB_BYTE_STROBE_EN
  input  logic [1:0]    req1_strb_i,
`endif
  output logic          mem_we_lo_o,
  output logic          mem_we_hi_o,
  output logic [AW-1:0] mem_wa_o,
  output logic [DW-1:0] mem_wd_o,
  output logic          busy_o,
  output logic [7:0]    conflict_cnt_o
);
  typedef struct packed {
    logic [1:0]    strb;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_ent_t;

  wr_ent_t       ent0_in, ent1_in, head0, head1, gnt_ent;
  logic [1:0]    strb0, strb1, empty, full, pop;
  logic          both_vld, gnt_vld, gnt_idx;
  logic          we_lo_q, we_lo_d, we_hi_q, we_hi_d, last_grant_q, last_grant_d;
  logic [AW-1:0] wa_q, wa_d;
  logic [DW-1:0] wd_q, wd_d;
  logic [7:0]    cc_q, cc_d;

`ifdef WARB_BYTE_STROBE_EN
  assign strb0 = req0_strb_i;
  assign strb1 = req1_strb_i;
`else
  assign strb0 = 2'b11;
  assign strb1 = 2'b11;
`endif

  assign ent0_in      = {strb0, req0_addr_i, req0_data_i};
  assign ent1_in      = {strb1, req1_addr_i, req1_data_i};
  assign req0_ready_o = !full[0];
  assign req1_ready_o = !full[1];

  mem_wr_arbiter_fifo #(.DEPTH(DEPTH), .W($bits(wr_ent_t))) u_fifo0 (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (req0_valid_i),
    .dat_i   (ent0_in),
    .pop_i   (pop[0]),
    .dat_o   (head0),
    .empty_o (empty[0]),
    .full_o  (full[0])
  );

  mem_wr_arbiter_fifo #(.DEPTH(DEPTH), .W($bits(wr_ent_t))) u_fifo1 (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (req1_valid_i),
    .dat_i   (ent1_in),
    .pop_i   (pop[1]),
    .dat_o   (head1),
    .empty_o (empty[1]),
    .full_o  (full[1])
  );

  always_comb begin
    both_vld = !empty[0] && !empty[1];
    gnt_vld  = !empty[0] || !empty[1];
    // On a tie the loser of the previous grant wins; otherwise the only non-empty side.
    gnt_idx  = both_vld ? !last_grant_q : empty[0];
    gnt_ent  = gnt_idx ? head1 : head0;
    pop      = {gnt_vld && gnt_idx, gnt_vld && !gnt_idx};

    we_lo_d      = 1'b0;
    we_hi_d      = 1'b0;
    wa_d         = wa_q;
    wd_d         = wd_q;
    last_grant_d = last_grant_q;
    cc_d         = cc_q;
    if (gnt_vld) begin
      we_lo_d      = gnt_ent.strb[0];
      we_hi_d      = gnt_ent.strb[1];
      wa_d         = gnt_ent.addr;
      wd_d         = gnt_ent.data;
      last_grant_d = gnt_idx;
    end
    if (both_vld && cc_q != 8'hFF) cc_d = cc_q + 8'd1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      we_lo_q      <= 1'b0;
      we_hi_q      <= 1'b0;
      wa_q         <= '0;
      wd_q         <= '0;
      last_grant_q <= 1'b1;
      cc_q         <= 8'd0;
    end else begin
      we_lo_q      <= we_lo_d;
      we_hi_q      <= we_hi_d;
      wa_q         <= wa_d;
      wd_q         <= wd_d;
      last_grant_q <= last_grant_d;
      cc_q         <= cc_d;
    end
  end

  assign mem_we_lo_o    = we_lo_q;
  assign mem_we_hi_o    = we_hi_q;
  assign mem_wa_o       = wa_q;
  assign mem_wd_o       = wd_q;
  assign conflict_cnt_o = cc_q;
  assign busy_o         = gnt_vld || we_lo_q || we_hi_q;
endmodule

// File: doc/mem_wr_arbiter.md
# mem_wr_arbiter

Write scheduler for the shared 256×8 byte-addressed register memory that takes 16-bit word writes. Two independent requesters each present word writes through a valid/ready handshake. Each requester is buffered in its own FIFO, and a round-robin arbiter serialises the writes onto a single registered memory write port (word address plus low/high byte write enables). The block sits between the requesting engines and the memory and replaces any fixed-priority muxing of write ports.

## Interface
- DEPTH, 2, entries per requester FIFO; power of two, ≥2
- AW, 7, word address width; byte address is {addr, 1'b0} / {addr, 1'b1}
- DW, 16, word data width; [7:0] is the even byte, [15:8] the odd byte

Ports:
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- req0_valid  in  1  requester 0 has a write
- req0_ready  out  1  requester 0 FIFO can accept
- req0_addr  in  AW  requester 0 word address
- req0_data  in  DW  requester 0 write data
- req0_strb  in  2  requester 0 byte strobes {hi, lo}; present only with WARB_BYTE_STROBE_EN
- req1_valid / req1_ready / req1_addr / req1_data / req1_strb: same as req0_*, for requester 1
- mem_we_lo  out  1  write even byte this cycle
- mem_we_hi  out  1  write odd byte this cycle
- mem_wa  out  AW  word address of the issued write
- mem_wd  out  DW  data of the issued write
- busy  out  1  any FIFO non-empty or a write is on mem_*
- conflict_cnt  out  8  saturating count of cycles where both FIFOs were non-empty

## Operation
- Handshake: a push occurs at an edge where reqN_valid && reqN_ready. valid must hold with stable addr/data/strb until accepted.
- reqN_ready = (countN < DEPTH). It is low when full, even if a pop occurs in the same cycle.
- FIFOs: in-order per requester. Push and pop in the same cycle leave the count unchanged.
- Arbiter (combinational on FIFO empties plus register last_grant):
  - both non-empty: grant the requester ≠ last_grant;
  - one non-empty: grant it;
  - none: no grant.
- On a grant: pop the head of the granted FIFO, load mem_wa/mem_wd from it, set last_grant to the granted index.
- mem_we_lo/hi are registered. They are high for exactly one cycle per issued entry.
- Writes from different requesters to the same address land in grant order; the later grant wins.
- Round-robin bounds wait: with both FIFOs always non-empty, grants alternate 0,1,0,1…
- conflict_cnt increments at each edge where both FIFOs were non-empty; it saturates at 255.
- One grant per cycle. Peak memory throughput is 1 word/cycle.

## Timing
- Reset values: req*_ready=1, mem_we_lo=0, mem_we_hi=0, mem_wa=0, mem_wd=0, busy=0, conflict_cnt=0, last_grant=1 (requester 0 wins the first tie). FIFOs empty.
- Latency: a push at edge t to an empty FIFO with no contention gives mem_we high in the cycle after edge t+1. The memory captures the data at edge t+2.
- A contended entry waits at most one extra cycle behind the other requester's head.
- busy is combinational from FIFO counts and the registered mem_we.
- Reset mid-operation: FIFOs are flushed, mem_we_* drop asynchronously, and all buffered writes are discarded. No partial word write is ever issued.

## Configuration
- WARB_BYTE_STROBE_EN defined:
  - req*_strb ports exist and are stored with each FIFO entry;
  - mem_we_lo = issue && strb[0], mem_we_hi = issue && strb[1];
  - an entry with strb=2'b00 still consumes a grant and pops, but produces no write.
- Undefined: no strb ports; every issue drives mem_we_lo = mem_we_hi = 1.

## Test plan
- Single write: req0 addr=7'h05, data=16'hBEEF, idle req1 → one cycle with mem_we_lo=mem_we_hi=1, mem_wa=7'h05, mem_wd=16'hBEEF, two cycles after the accept edge.
- Simultaneous first pushes: req0 addr=1/data=16'h1111, req1 addr=1/data=16'h2222 → requester 0 issues first, then requester 1 next cycle (final memory word 16'h2222); conflict_cnt=1.
- Sustained contention: both requesters stream 8 writes each → grants strictly alternate 0,1,…; 16 consecutive mem_we cycles; conflict_cnt saturation check with more than 255 contended cycles → holds 255.
- Backpressure: hold req0_valid with memory draining blocked by continuous req1 contention, DEPTH=2 → req0_ready drops after 2 unserved pushes and rises the cycle after a pop.
- Reset mid-stream: assert rst_n=0 with 2 entries buffered and mem_we high → mem_we_* low immediately; after release, busy=0, ready=1, no further writes.
- With WARB_BYTE_STROBE_EN: strb=2'b10, data=16'hAB00 → only mem_we_hi; strb=2'b00 → grant and pop with no write enable.
